// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
// in_ready and out_valid come straight from state flops, so neither handshake path is combinational.
module pipe_skid_reg #(
  parameter int                 DATA_W     = 104,
  parameter logic [DATA_W-1:0]  RST_VAL    = '0,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_data;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_accept;
  logic                w_take;
  logic                w_stall;
  logic                w_main_load;
  logic                w_main_from_skid;
  logic                w_skid_load;

  // rstn gates in_ready so nothing upstream sees a handshake while the stage is held in reset.
  assign in_ready  = rstn && (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign stall_cnt = r_stall_cnt;

  assign w_accept = in_valid && in_ready;
  assign w_take   = out_valid && out_ready;
  assign w_stall  = out_valid && !out_ready;

  // NOTE: every signal written here gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_main_load = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_take) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_skid_load = 1'b1;
          w_state_nxt = TWO;
        end else if (w_take) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_take) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= EMPTY;
      r_main_data <= RST_VAL;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main_data <= BUBBLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_load) begin
        r_main_data <= w_main_from_skid ? r_skid_data : in_data;
      end
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while r_state == TWO.
  always_ff @(posedge clk) begin
    if (w_skid_load) begin
      r_skid_data <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed plus random handshake bench for pipe_skid_reg with a queue scoreboard.
// A 104-bit instance is checked beat by beat; a 4-bit-counter instance checks saturation.
module tb_pipe_skid_reg;

  localparam int                DATA_W = 104;
  localparam logic [DATA_W-1:0] RST_V  = 104'h1;
  localparam logic [DATA_W-1:0] BUB_V  = 104'hB0B;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              cnt_clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       stall_cnt;

  logic              in_ready4;
  logic              out_valid4;
  logic [7:0]        out_data4;
  logic [3:0]        stall_cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DATA_W), .RST_VAL(RST_V), .BUBBLE_VAL(BUB_V), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data[7:0]),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .stall_cnt(stall_cnt4)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queue of accepted beats, last value seen on out_data, and counter models.
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] sb_last;
  logic [15:0]       m_cnt;
  logic [3:0]        m_cnt4;
  bit                armed = 1'b0;

  // Inputs change 1 time unit after posedge; everything is sampled here on the negedge.
  always @(negedge clk) begin
    logic take, acc;
    if (armed) begin
      check("in_ready",   {127'd0, in_ready},  {127'd0, rstn && (sb_q.size() < 2)});
      check("out_valid",  {127'd0, out_valid}, {127'd0, sb_q.size() > 0});
      check("out_data",   out_data, (sb_q.size() > 0) ? sb_q[0] : sb_last);
      check("stall_cnt",  stall_cnt, m_cnt);
      check("stall_cnt4", stall_cnt4, m_cnt4);
    end
    if (!rstn) begin
      sb_q.delete();
      sb_last = RST_V;
      m_cnt   = '0;
      m_cnt4  = '0;
      armed   = 1'b1;
    end else if (armed) begin
      if (cnt_clr) begin
        m_cnt  = '0;
        m_cnt4 = '0;
      end else if (sb_q.size() > 0 && !out_ready) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt4 != 4'hF)    m_cnt4 = m_cnt4 + 4'd1;
      end
      take = (sb_q.size() > 0) && out_ready;
      acc  = in_valid && (sb_q.size() < 2);
      if (take) sb_last = sb_q.pop_front();
      if (flush) begin
        sb_q.delete();
        sb_last = BUB_V;
      end else if (acc) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    logic [127:0] rnd;
    rstn = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 104'h55; out_ready = 1'b0;
    repeat (3) cyc();
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    rstn = 1'b1; in_valid = 1'b0;
    cyc();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data",  out_data, 128'h1);
    check("rst_in_ready1", {127'd0, in_ready}, 128'd1);
    check("rst_stall_cnt", stall_cnt, 128'd0);

    // Streaming at one beat per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 104'h10 + DATA_W'(i);
      cyc();
      check("stream_data",  out_data, 128'h10 + 128'(i));
      check("stream_ready", {127'd0, in_ready}, 128'd1);
    end
    idle();
    cyc();

    // Backpressure: A to main, B to skid, C held upstream.
    out_ready = 1'b0;
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 104'hA; cyc();
    in_data = 104'hB; cyc();
    in_data = 104'hC; cyc();
    check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    check("bp_main",     out_data, 128'hA);
    check("bp_stall",    stall_cnt, 128'd2);
    out_ready = 1'b1; cyc();
    check("bp_second",   out_data, 128'hB);
    cyc();
    check("bp_third",    out_data, 128'hC);
    idle(); cyc();

    // Flush in TWO with a coincident beat.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 104'h21; cyc();
    in_data = 104'h22; cyc();
    in_data = 104'h23; flush = 1'b1; cyc();
    check("fl_out_valid", {127'd0, out_valid}, 128'd0);
    check("fl_out_data",  out_data, 128'hB0B);
    check("fl_in_ready",  {127'd0, in_ready}, 128'd1);
    idle(); cyc();

    // Counter saturation on the 4-bit instance, then clear during a stall.
    in_valid = 1'b1; in_data = 104'h31; cnt_clr = 1'b1; cyc();
    idle();
    repeat (20) cyc();
    check("cnt4_sat", stall_cnt4, 128'd15);
    check("cnt16_20", stall_cnt,  128'd20);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    check("cnt4_clr", stall_cnt4, 128'd0);
    check("cnt16_clr", stall_cnt, 128'd0);
    out_ready = 1'b1; cyc();

    // Random traffic with occasional flush, clear and reset.
    for (int i = 0; i < 10000; i++) begin
      rnd       = {$urandom, $urandom, $urandom, $urandom};
      in_data   = rnd[DATA_W-1:0];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      cnt_clr   = ($urandom_range(0, 99) == 0);
      rstn      = ($urandom_range(0, 499) != 0);
      cyc();
    end
    idle(); rstn = 1'b1; out_ready = 1'b1;
    repeat (4) cyc();
    check("drain_empty", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It generalises the fixed EX/MEM-style stage register to any payload width. A fully registered in_ready breaks the backpressure path, and it adds flush (bubble insertion) and a saturating stall counter. It is instantiated between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a packed control+data payload.

Parameters:
DATA_W, 104, payload width in bits (packed WB/M ctrl, PC, ALU result, Rd, flags).
RST_VAL, '0, out_data value loaded on reset (lets ctrl bits such as an active-low CS reset to inactive).
BUBBLE_VAL, '0, out_data value loaded on flush (NOP encoding of the payload).
CNT_W, 16, width of stall_cnt.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset, synchronous, active-low.
flush  in  1  synchronous kill of all held beats.
cnt_clr  in  1  synchronous clear of stall_cnt.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat; registered.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  downstream beat valid.
out_ready  in  1  downstream accepts beat.
out_data  out  DATA_W  payload to downstream; registered.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Accept: in_valid && in_ready at a clk edge. Take: out_valid && out_ready at a clk edge.
- Storage: main register (drives out_data/out_valid) plus skid register (skid_data, skid_valid).
- States:
  - EMPTY: out_valid=0, skid empty.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- Outputs decoded from state flops only: in_ready = (state != TWO); out_valid = (state != EMPTY). No combinational in->out path.
- Transitions (rstn=1, flush=0):
  - EMPTY: accept -> main<=in_data, ONE.
  - ONE: accept & take -> main<=in_data, stay ONE. Accept & !take -> skid<=in_data, TWO. Take & !accept -> EMPTY. Neither -> hold.
  - TWO: take -> main<=skid_data, ONE (no accept possible, in_ready=0). No take -> hold everything.
- Latency: 1 cycle in->out from EMPTY. Sustained throughput 1 beat/cycle with out_ready=1.
- Ordering: strict FIFO. No beat is lost or duplicated except on flush/reset.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change.
- Empty: out_data keeps its last value after the final take (don't-care to downstream, but must not toggle).
- Flush (priority below reset, above everything else): next state EMPTY, skid_valid<=0, out_data<=BUBBLE_VAL. A beat accepted in the same cycle as flush is discarded. A take in the same cycle completes downstream as normal.
- Reset (rstn=0 at edge): state EMPTY, out_valid=0, out_data=RST_VAL, skid_valid=0, stall_cnt=0.
  - in_ready is additionally gated to 0 while rstn=0, so no beat is accepted during reset.
  - Reset mid-TWO drops both beats.
- stall_cnt:
  - +1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 and takes priority over increment.
  - Flush does not clear it.
- Skid data register needs no reset. Its contents are valid only with skid_valid.

Test Plan:
- Reset with DATA_W=104, RST_VAL=104'h1 (CS bit) -> after release: out_valid=0, out_data=1, in_ready=1, stall_cnt=0. in_valid=1 during reset -> nothing accepted.
- Streaming: in_data=0x10,0x11,0x12,0x13 back-to-back, out_ready=1 -> out_data 0x10..0x13 on consecutive cycles starting 1 cycle after the first accept, in_ready held 1.
- Backpressure: send 0xA,0xB,0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0 after 2 accepts, 0xC held upstream. Raise out_ready -> outputs 0xA,0xB,0xC in order, stall_cnt equals stalled cycles.
- Flush in state TWO with simultaneous in_valid -> next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1. The coincident beat never appears at out.
- Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). cnt_clr pulse together with a stall cycle -> stall_cnt=0.
- Random valid/ready for 10k cycles against a scoreboard -> order preserved, zero loss/duplication, out_data stable during every stall.
